hangman_round_engine: RTL and testbench

- Parametrised successor to the game datapath. Runs one full hangman round:
  - player 1 enters a word;
  - player 2 guesses letters;
  - the engine scans the stored word sequentially, tracks revealed positions and misses, requests hangman part drawing over a handshake, enforces a per-guess turn timeout, and keeps both players' scores.
- Sits between the keyboard/char decoder and the VGA drawing FSM.

---
 rtl/hangman_pkg.sv | 21 ++
 rtl/hangman_round_engine_turn_timer.sv | 29 ++
 rtl/hangman_round_engine.sv | 202 ++++++++++++++++++++
 tb/tb_hangman_round_engine.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman round engine: state encoding, alphabet size
// and character validation.
package hangman_pkg;

  localparam int unsigned LETTERS    = 26;
  localparam int          DEF_CHAR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_GUESS = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DRAW  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic valid_char(input int unsigned code);
    return code < LETTERS;
  endfunction

endpackage

// File: rtl/hangman_round_engine_turn_timer.sv
// Per-guess countdown. Held at full count while load is high; expire stays
// asserted once the budget is spent so a turn that ends on a rejected ld still times out.
module turn_timer #(
  parameter int unsigned TURN_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TURN_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TURN_CYCLES);
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = enable && (count <= CNT_W'(1));

endmodule

// File: rtl/hangman_round_engine.sv
// One hangman round: word entry, sequential guess scanning, miss drawing handshake,
// per-turn timeout and saturating player scores.
module hangman_round_engine
  import hangman_pkg::*;
#(
  parameter int          MAX_LEN     = 8,
  parameter int          CHAR_W      = DEF_CHAR_W,
  parameter int          MAX_MISS    = 9,
  parameter int unsigned TURN_CYCLES = 50000000,
  parameter int          SCORE_W     = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          new_round,
  input  logic [CHAR_W-1:0]             char_in,
  input  logic                          ld,
  input  logic                          word_done,
  input  logic                          draw_done,
  input  logic [$clog2(MAX_LEN)-1:0]    rd_idx,
  output logic [CHAR_W-1:0]             rd_char,
  output logic [MAX_LEN-1:0]            revealed,
  output logic [$clog2(MAX_LEN+1)-1:0]  word_len,
  output logic [$clog2(MAX_MISS+1)-1:0] misses,
  output logic                          draw_req,
  output logic [$clog2(MAX_MISS+1)-1:0] draw_part,
  output logic                          match,
  output logic                          dup,
  output logic                          bad_char,
  output logic                          timeout,
  output logic                          round_over,
  output logic                          p2_won,
  output logic [SCORE_W-1:0]            p1_score,
  output logic [SCORE_W-1:0]            p2_score
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int IDX_W  = $clog2(MAX_LEN);
  localparam int MISS_W = $clog2(MAX_MISS + 1);

  state_t             state;
  logic [CHAR_W-1:0]  word [MAX_LEN];
  logic [CHAR_W-1:0]  guess;
  logic [LETTERS-1:0] guessed;
  logic [IDX_W-1:0]   idx;
  logic               hit_seen;

  logic               char_ok;
  logic               store_ok;
  logic               last_pos;
  logic               expire;
  logic               scan_hit;
  logic [MAX_LEN-1:0] revealed_scan;
  logic [MAX_LEN-1:0] len_mask;

  assign char_ok  = valid_char(32'(char_in));
  assign store_ok = ld && char_ok && (word_len < LEN_W'(MAX_LEN));
  assign last_pos = (LEN_W'(idx) == (word_len - LEN_W'(1)));
  assign rd_char  = word[rd_idx];

  turn_timer #(.TURN_CYCLES(TURN_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (resetn),
    .load   (state != ST_GUESS),
    .enable (state == ST_GUESS),
    .expire (expire)
  );

  // Current scan position compare and the mask of positions that belong to the word.
  always_comb begin
    scan_hit      = 1'b0;
    revealed_scan = revealed;
    len_mask      = '0;
    if ((word[idx] == guess) && !revealed[idx]) begin
      scan_hit           = 1'b1;
      revealed_scan[idx] = 1'b1;
    end else begin
      scan_hit = 1'b0;
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(word_len)) len_mask[i] = 1'b1;
      else                    len_mask[i] = 1'b0;
    end
  end

  // Round control FSM with all outputs registered.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state      <= ST_IDLE;
      for (int i = 0; i < MAX_LEN; i++) word[i] <= '0;
      guess      <= '0;
      guessed    <= '0;
      idx        <= '0;
      hit_seen   <= 1'b0;
      revealed   <= '0;
      word_len   <= '0;
      misses     <= '0;
      draw_req   <= 1'b0;
      draw_part  <= '0;
      match      <= 1'b0;
      dup        <= 1'b0;
      bad_char   <= 1'b0;
      timeout    <= 1'b0;
      round_over <= 1'b0;
      p2_won     <= 1'b0;
      p1_score   <= '0;
      p2_score   <= '0;
    end else begin
      match    <= 1'b0;
      dup      <= 1'b0;
      bad_char <= 1'b0;
      timeout  <= 1'b0;
      if (new_round) begin
        // Abort wins over everything; scores are intentionally kept.
        state      <= ST_ENTRY;
        word_len   <= '0;
        revealed   <= '0;
        misses     <= '0;
        guessed    <= '0;
        idx        <= '0;
        hit_seen   <= 1'b0;
        draw_req   <= 1'b0;
        draw_part  <= '0;
        round_over <= 1'b0;
        p2_won     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_ENTRY: begin
            if (store_ok) begin
              word[word_len[IDX_W-1:0]] <= char_in;
              word_len <= word_len + LEN_W'(1);
            end else if (ld) begin
              bad_char <= 1'b1;
            end
            if (word_done && ((word_len != '0) || store_ok)) state <= ST_GUESS;
          end
          ST_GUESS: begin
            if (ld) begin
              if (!char_ok) begin
                bad_char <= 1'b1;
              end else if (guessed[char_in]) begin
                dup <= 1'b1;
              end else begin
                guessed[char_in] <= 1'b1;
                guess    <= char_in;
                idx      <= '0;
                hit_seen <= 1'b0;
                state    <= ST_SCAN;
              end
            end else if (expire) begin
              timeout   <= 1'b1;
              misses    <= misses + MISS_W'(1);
              draw_part <= misses + MISS_W'(1);
              draw_req  <= 1'b1;
              state     <= ST_DRAW;
            end
          end
          ST_SCAN: begin
            revealed <= revealed_scan;
            if (last_pos) begin
              if (hit_seen || scan_hit) begin
                match <= 1'b1;
                if ((revealed_scan & len_mask) == len_mask) begin
                  state      <= ST_DONE;
                  round_over <= 1'b1;
                  p2_won     <= 1'b1;
                  if (p2_score != '1) p2_score <= p2_score + SCORE_W'(1);
                end else begin
                  state <= ST_GUESS;
                end
              end else begin
                misses    <= misses + MISS_W'(1);
                draw_part <= misses + MISS_W'(1);
                draw_req  <= 1'b1;
                state     <= ST_DRAW;
              end
            end else begin
              idx      <= idx + IDX_W'(1);
              hit_seen <= hit_seen || scan_hit;
            end
          end
          ST_DRAW: begin
            if (draw_done) begin
              draw_req <= 1'b0;
              if (misses == MISS_W'(MAX_MISS)) begin
                state      <= ST_DONE;
                round_over <= 1'b1;
                p2_won     <= 1'b0;
                if (p1_score != '1) p1_score <= p1_score + SCORE_W'(1);
              end else begin
                state <= ST_GUESS;
              end
            end
          end
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hangman_round_engine.sv
// Scoreboard bench for hangman_round_engine: a reference model pushes expected
// outputs when stimulus is driven; they are popped and compared once the DUT responds.
module tb_hangman_round_engine;

  localparam int MAX_LEN     = 8;
  localparam int CHAR_W      = 5;
  localparam int MAX_MISS    = 3;
  localparam int TURN_CYCLES = 20;
  localparam int SCORE_W     = 4;

  logic clk = 1'b0;
  logic resetn, new_round, ld, word_done, draw_done;
  logic [CHAR_W-1:0] char_in;
  logic [2:0] rd_idx;
  logic [CHAR_W-1:0] rd_char;
  logic [7:0] revealed;
  logic [3:0] word_len;
  logic [1:0] misses, draw_part;
  logic draw_req, match, dup, bad_char, timeout, round_over, p2_won;
  logic [SCORE_W-1:0] p1_score, p2_score;

  hangman_round_engine #(
    .MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .MAX_MISS(MAX_MISS),
    .TURN_CYCLES(TURN_CYCLES), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .resetn(resetn), .new_round(new_round), .char_in(char_in), .ld(ld),
    .word_done(word_done), .draw_done(draw_done), .rd_idx(rd_idx), .rd_char(rd_char),
    .revealed(revealed), .word_len(word_len), .misses(misses), .draw_req(draw_req),
    .draw_part(draw_part), .match(match), .dup(dup), .bad_char(bad_char),
    .timeout(timeout), .round_over(round_over), .p2_won(p2_won),
    .p1_score(p1_score), .p2_score(p2_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          m_word[MAX_LEN];
  int          m_len, m_misses, m_p1, m_p2;
  logic [7:0]  m_rev;
  logic [25:0] m_guessed;
  logic        m_done, m_p2won;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int observe(input string tag);
    case (tag)
      "bad_char":   return int'(bad_char);
      "dup":        return int'(dup);
      "match":      return int'(match);
      "timeout":    return int'(timeout);
      "draw_req":   return int'(draw_req);
      "draw_part":  return int'(draw_part);
      "revealed":   return int'(revealed);
      "misses":     return int'(misses);
      "word_len":   return int'(word_len);
      "round_over": return int'(round_over);
      "p2_won":     return int'(p2_won);
      "p1_score":   return int'(p1_score);
      "p2_score":   return int'(p2_score);
      default:      return -1;
    endcase
  endfunction

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.tag), e.val);
    end
  endtask

  task automatic push_round_state();
    push("revealed", int'(m_rev));
    push("misses", m_misses);
    push("round_over", int'(m_done));
    push("p2_won", int'(m_p2won));
    push("p1_score", m_p1);
    push("p2_score", m_p2);
  endtask

  task automatic start_round();
    m_len = 0; m_rev = '0; m_misses = 0; m_guessed = '0; m_done = 1'b0; m_p2won = 1'b0;
    push("word_len", 0);
    push("draw_req", 0);
    push_round_state();
    @(negedge clk); new_round = 1'b1;
    @(posedge clk); #1; new_round = 1'b0;
    drain();
  endtask

  task automatic enter(input int c);
    if (c < 26 && m_len < MAX_LEN) begin
      m_word[m_len] = c;
      m_len++;
      push("bad_char", 0);
    end else begin
      push("bad_char", 1);
    end
    push("word_len", m_len);
    @(negedge clk); char_in = CHAR_W'(c); ld = 1'b1;
    @(posedge clk); #1; ld = 1'b0;
    drain();
  endtask

  task automatic finish_entry();
    @(negedge clk); word_done = 1'b1;
    @(posedge clk); #1; word_done = 1'b0;
    for (int i = 0; i < m_len; i++) begin
      rd_idx = 3'(i);
      #0.5;
      check_eq("rd_char", int'(rd_char), m_word[i]);
    end
  endtask

  task automatic guess(input int c);
    int cycles;
    int kind;
    logic [7:0] nrev;
    logic [7:0] full;
    nrev = m_rev;
    full = 8'((1 << m_len) - 1);
    if (c >= 26) kind = 0;
    else if (m_guessed[c]) kind = 1;
    else begin
      m_guessed[c] = 1'b1;
      kind = 3;
      for (int i = 0; i < m_len; i++) begin
        if (m_word[i] == c) begin
          nrev[i] = 1'b1;
          kind = 2;
        end
      end
    end
    push("bad_char", int'(kind == 0));
    push("dup", int'(kind == 1));
    if (kind == 2) begin
      m_rev = nrev;
      push("match", 1);
      push("draw_req", 0);
      if (m_rev == full) begin
        m_done = 1'b1; m_p2won = 1'b1;
        if (m_p2 < 15) m_p2++;
      end
    end else if (kind == 3) begin
      m_misses++;
      push("match", 0);
      push("draw_req", 1);
      push("draw_part", m_misses);
    end
    push_round_state();
    @(negedge clk); char_in = CHAR_W'(c); ld = 1'b1;
    @(posedge clk); #1; ld = 1'b0;
    if (kind >= 2) begin
      cycles = 0;
      while (!(match || draw_req) && cycles < 40) begin
        @(posedge clk); #1;
        cycles++;
      end
      check_eq("scan_latency", cycles, m_len);
    end
    drain();
  endtask

  task automatic ack(input int delay);
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      check_eq("draw_req_hold", int'(draw_req), 1);
      check_eq("draw_part_hold", int'(draw_part), m_misses);
    end
    @(negedge clk); draw_done = 1'b1;
    @(posedge clk); #1; draw_done = 1'b0;
    if (m_misses == MAX_MISS) begin
      m_done = 1'b1; m_p2won = 1'b0;
      if (m_p1 < 15) m_p1++;
    end
    push("draw_req", 0);
    push_round_state();
    drain();
  endtask

  task automatic wait_timeout();
    int cycles;
    cycles = 0;
    while (!timeout && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_eq("timeout_latency", cycles, TURN_CYCLES);
    m_misses++;
    push("timeout", 1);
    push("draw_req", 1);
    push("draw_part", m_misses);
    push_round_state();
    drain();
    @(posedge clk); #1;
    check_eq("timeout_pulse", int'(timeout), 0);
  endtask

  initial begin
    new_round = 1'b0; ld = 1'b0; word_done = 1'b0; draw_done = 1'b0;
    char_in = '0; rd_idx = '0;
    m_p1 = 0; m_p2 = 0; m_len = 0; m_rev = '0; m_misses = 0; m_guessed = '0;
    m_done = 1'b0; m_p2won = 1'b0;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    push("word_len", 0); push("draw_req", 0); push("draw_part", 0); push("match", 0);
    push("timeout", 0); push_round_state();
    drain();

    // Word "CAB", first hit, pulse width
    start_round();
    enter(2); enter(0); enter(1);
    finish_entry();
    guess(0);
    check_eq("revealed_first", int'(revealed), 8'b0000_0010);
    @(posedge clk); #1;
    check_eq("match_pulse", int'(match), 0);

    // Duplicate, invalid, miss with slow acknowledge, then win
    guess(0);
    guess(30);
    guess(25);
    ack(5);
    guess(2);
    guess(1);
    check_eq("revealed_win", int'(revealed), 8'b0000_0111);

    // Overflowing entry, two misses and a timeout lose the round
    start_round();
    for (int c = 3; c < 12; c++) enter(c);
    finish_entry();
    guess(25);
    ack(1);
    guess(24);
    ack(0);
    wait_timeout();
    ack(0);

    // Async reset while a part is being drawn
    start_round();
    enter(2); enter(0); enter(1);
    finish_entry();
    guess(2);
    guess(25);
    #2; resetn = 1'b1;
    #1;
    m_len = 0; m_rev = '0; m_misses = 0; m_guessed = '0; m_done = 1'b0; m_p2won = 1'b0;
    m_p1 = 0; m_p2 = 0;
    push("draw_req", 0); push("draw_part", 0); push("word_len", 0);
    push_round_state();
    drain();
    @(negedge clk); @(negedge clk); resetn = 1'b0;
    @(negedge clk); char_in = 5'd3; ld = 1'b1; word_done = 1'b1;
    @(posedge clk); #1; ld = 1'b0; word_done = 1'b0;
    @(posedge clk); #1;
    push("word_len", 0); push("bad_char", 0);
    push_round_state();
    drain();
    rd_idx = 3'd0; #1;
    check_eq("rd_char_idle", int'(rd_char), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
